// File: rtl/cpu_trace_tx.sv
`default_nettype none
// ============================================================================
// Module   : cpu_trace_tx
// Purpose  : CPU execution trace transmitter: cycle/stall/flush counters, PC
//            snapshot FIFO and valid/ready frame serialiser. Defining
//            CPU_TRACE_TX_REGS_EN appends NREG register-file words per frame.
// Revision : 1.0
// ============================================================================
module cpu_trace_tx #(
    parameter int SNAP_DEPTH = 2,
    parameter int NREG       = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        sample_i,
`ifdef CPU_TRACE_TX_REGS_EN
    output logic [4:0]  reg_addr_o,
    input  logic [31:0] reg_data_i,
`endif
    output logic [31:0] tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        tx_last_o
);

`ifdef CPU_TRACE_TX_REGS_EN
    localparam int c_REG_WORDS = NREG;
`else
    // NREG has no effect when register words are not transmitted.
    localparam int c_REG_WORDS = 0 * NREG;
`endif
    localparam int c_NWORDS   = 4 + c_REG_WORDS;
    localparam int c_WIDX_W   = $clog2(c_NWORDS);
    localparam int c_AW       = $clog2(SNAP_DEPTH);
    localparam logic [7:0] c_SYNC = 8'hA5;

    typedef struct packed {
        logic [15:0] seq;
        logic [7:0]  drop;
        logic [31:0] cycle;
        logic [31:0] pc;
        logic [15:0] stall;
        logic [15:0] flush;
    } snap_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    logic [31:0]         r_cycle_cnt;
    logic [15:0]         r_stall_cnt;
    logic [15:0]         r_flush_cnt;
    logic [15:0]         r_seq;
    logic [7:0]          r_drop_cnt;

    logic                w_push;
    logic                w_push_acc;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_has_next;
    logic [c_AW:0]       r_wr_ptr;
    logic [c_AW:0]       r_rd_ptr;
    logic [c_AW:0]       w_count;
    logic [c_AW-1:0]     w_rd_idx;
    logic [c_AW-1:0]     w_rd_idx_nxt;
    snap_t               r_mem [SNAP_DEPTH];
    snap_t               w_push_snap;
    snap_t               w_head;
    snap_t               w_next_head;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_tx_data;
    logic [31:0]         w_data_nxt;
    logic                r_tx_valid;
    logic                w_valid_nxt;
    logic                r_tx_last;
    logic                w_last_nxt;
    logic [c_WIDX_W-1:0] r_widx;
    logic [c_WIDX_W-1:0] w_widx_nxt;
    logic [c_WIDX_W-1:0] w_widx_inc;
    logic [31:0]         w_reg_data;

    function automatic logic [31:0] f_word(input logic [c_WIDX_W-1:0] idx,
                                           input snap_t               s,
                                           input logic [31:0]         rdata);
        logic [31:0] w;
        case (int'(idx))
            0:       w = {c_SYNC, s.drop, s.seq};
            1:       w = s.cycle;
            2:       w = s.pc;
            3:       w = {s.stall, s.flush};
            default: w = rdata;
        endcase
        return w;
    endfunction

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cycle_cnt <= 32'd0;
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
            r_seq       <= 16'd0;
            r_drop_cnt  <= 8'd0;
        end else if (start_i) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (stall_i && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (flush_i && (r_flush_cnt != 16'hFFFF))
                r_flush_cnt <= r_flush_cnt + 16'd1;
            if (sample_i) begin
                if (w_push_acc) begin
                    r_seq      <= r_seq + 16'd1;
                    r_drop_cnt <= 8'd0;
                end else if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Snapshot FIFO
    // ------------------------------------------------------------------
    assign w_push_snap  = {r_seq, r_drop_cnt, r_cycle_cnt, pc_i, r_stall_cnt, r_flush_cnt};
    assign w_count      = r_wr_ptr - r_rd_ptr;
    assign w_empty      = (w_count == '0);
    assign w_full       = (w_count == (c_AW+1)'(SNAP_DEPTH));
    assign w_rd_idx     = r_rd_ptr[c_AW-1:0];
    assign w_rd_idx_nxt = w_rd_idx + c_AW'(1);
    assign w_head       = r_mem[w_rd_idx];

    assign w_pop      = (r_state == ST_SEND) && tx_ready_i && r_tx_last;
    assign w_push     = sample_i && start_i;
    assign w_push_acc = w_push && (!w_full || w_pop);
    assign w_has_next = (w_count > (c_AW+1)'(1)) || w_push_acc;
    // With only the departing entry queued, a same-edge push is forwarded so
    // back-to-back frames stay gap-free.
    assign w_next_head = (w_count > (c_AW+1)'(1)) ? r_mem[w_rd_idx_nxt] : w_push_snap;

    always_ff @(posedge clk_i) begin
        if (w_push_acc)
            r_mem[r_wr_ptr[c_AW-1:0]] <= w_push_snap;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_acc)
                r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
        end
    end

    // ------------------------------------------------------------------
    // Register-word source
    // ------------------------------------------------------------------
`ifdef CPU_TRACE_TX_REGS_EN
    logic [4:0] w_reg_addr;

    always_comb begin
        w_reg_addr = 5'd0;
        if ((r_state == ST_SEND) && !r_tx_last && (int'(w_widx_inc) >= 4))
            w_reg_addr = 5'(int'(w_widx_inc) - 4);
    end

    assign reg_addr_o = w_reg_addr;
    assign w_reg_data = reg_data_i;
`else
    assign w_reg_data = 32'd0;
`endif

    // ------------------------------------------------------------------
    // Frame serialiser FSM
    // ------------------------------------------------------------------
    assign w_widx_inc = r_widx + c_WIDX_W'(1);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= ST_IDLE;
            r_tx_data  <= 32'd0;
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
            r_widx     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_data  <= w_data_nxt;
            r_tx_valid <= w_valid_nxt;
            r_tx_last  <= w_last_nxt;
            r_widx     <= w_widx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_tx_data;
        w_valid_nxt = r_tx_valid;
        w_last_nxt  = r_tx_last;
        w_widx_nxt  = r_widx;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = ST_SEND;
                    w_data_nxt  = f_word('0, w_head, w_reg_data);
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = 1'b0;
                    w_widx_nxt  = '0;
                end
            end
            ST_SEND: begin
                if (tx_ready_i) begin
                    if (r_tx_last) begin
                        w_widx_nxt = '0;
                        w_last_nxt = 1'b0;
                        if (w_has_next) begin
                            w_data_nxt = f_word('0, w_next_head, w_reg_data);
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_valid_nxt = 1'b0;
                        end
                    end else begin
                        w_widx_nxt = w_widx_inc;
                        w_data_nxt = f_word(w_widx_inc, w_head, w_reg_data);
                        w_last_nxt = (int'(w_widx_inc) == c_NWORDS - 1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
            end
        endcase
    end

    assign tx_data_o  = r_tx_data;
    assign tx_valid_o = r_tx_valid;
    assign tx_last_o  = r_tx_last;

endmodule
`default_nettype wire

// File: tb/tb_cpu_trace_tx.sv
`default_nettype none
// Testbench for cpu_trace_tx: queue-based frame model compared every cycle,
// plus literal frame expectations from directed scenarios.
module tb_cpu_trace_tx;
    localparam int SNAP_DEPTH = 2;
    localparam int NREG       = 2;
`ifdef CPU_TRACE_TX_REGS_EN
    localparam int NW = 4 + NREG;
`else
    localparam int NW = 4;
`endif

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic [31:0] pc       = 32'd0;
    logic        stall    = 1'b0;
    logic        flush    = 1'b0;
    logic        sample   = 1'b0;
    logic        tx_ready = 1'b0;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic [31:0] regs [32];
`ifdef CPU_TRACE_TX_REGS_EN
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    assign reg_data = regs[reg_addr];
`endif

    always #5 clk = ~clk;

    cpu_trace_tx #(.SNAP_DEPTH(SNAP_DEPTH), .NREG(NREG)) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .start_i    (start),
        .pc_i       (pc),
        .stall_i    (stall),
        .flush_i    (flush),
        .sample_i   (sample),
`ifdef CPU_TRACE_TX_REGS_EN
        .reg_addr_o (reg_addr),
        .reg_data_i (reg_data),
`endif
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .tx_last_o  (tx_last)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: queue of whole frames, current word index.
    logic [127:0] mq [$];
    bit           m_busy = 1'b0;
    int           m_widx = 0;
    logic [31:0]  m_cyc   = 32'd0;
    logic [15:0]  m_stall = 16'd0;
    logic [15:0]  m_flush = 16'd0;
    logic [15:0]  m_seq   = 16'd0;
    logic [7:0]   m_drop  = 8'd0;
    bit           m_idle_load;
    bit           m_pop;
    bit           m_pacc;
    logic [127:0] m_nf;

    function automatic logic [31:0] exp_word();
        logic [127:0] f;
        f = mq[0];
        if (m_widx < 4) return f[(3 - m_widx) * 32 +: 32];
        return regs[5'(m_widx - 4)];
    endfunction

    function automatic logic [31:0] exp_reg_addr();
        if (m_busy && (m_widx < NW - 1) && (m_widx + 1 >= 4)) return 32'(m_widx + 1 - 4);
        return 32'd0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_busy = 1'b0; m_widx = 0;
            m_cyc = 32'd0; m_stall = 16'd0; m_flush = 16'd0; m_seq = 16'd0; m_drop = 8'd0;
        end else begin
            m_idle_load = !m_busy && (mq.size() > 0);
            m_pop       = m_busy && tx_ready && (m_widx == NW - 1);
            m_pacc      = 1'b0;
            if (start && sample) begin
                if ((mq.size() < SNAP_DEPTH) || m_pop) begin
                    m_pacc = 1'b1;
                    m_nf   = {8'hA5, m_drop, m_seq, m_cyc, pc, m_stall, m_flush};
                    m_seq  = m_seq + 16'd1;
                    m_drop = 8'd0;
                end else if (m_drop != 8'hFF) begin
                    m_drop = m_drop + 8'd1;
                end
            end
            if (start) begin
                m_cyc = m_cyc + 32'd1;
                if (stall && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
                if (flush && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
            end
            if (m_pop) void'(mq.pop_front());
            if (m_pacc) mq.push_back(m_nf);
            if (m_idle_load) begin
                m_busy = 1'b1; m_widx = 0;
            end else if (m_busy && tx_ready) begin
                if (!m_pop) m_widx++;
                else if (mq.size() > 0) m_widx = 0;
                else begin m_busy = 1'b0; m_widx = 0; end
            end
        end
    end

    logic [32:0] rx [$];
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data  = 32'd0;
    logic        prev_last  = 1'b0;
    int          cyc = 0;
    int          first_v = -1;
    int          last_v  = -1;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_valid", 32'(tx_valid), 32'd0);
            chk("rst_last", 32'(tx_last), 32'd0);
            chk("rst_data", tx_data, 32'd0);
`ifdef CPU_TRACE_TX_REGS_EN
            chk("rst_reg_addr", 32'(reg_addr), 32'd0);
`endif
            prev_stall = 1'b0;
        end else begin
            chk("valid", 32'(tx_valid), 32'(m_busy));
            if (m_busy) begin
                chk("data", tx_data, exp_word());
                chk("last", 32'(tx_last), 32'(m_widx == NW - 1));
            end
`ifdef CPU_TRACE_TX_REGS_EN
            chk("reg_addr", 32'(reg_addr), exp_reg_addr());
`endif
            if (prev_stall) begin
                chk("hold_valid", 32'(tx_valid), 32'd1);
                chk("hold_data", tx_data, prev_data);
                chk("hold_last", 32'(tx_last), 32'(prev_last));
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_last  = tx_last;
            if (tx_valid) begin
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end
            if (tx_valid && tx_ready) rx.push_back({tx_last, tx_data});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; sample = 1'b0; stall = 1'b0; flush = 1'b0;
        tx_ready = 1'b1;
        tick(2);
        rst_n = 1'b1;
        rx.delete();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[1] = 32'h7;

        // Reset state
        tick(2);
        chk("reset_valid", 32'(tx_valid), 32'd0);
        chk("reset_data", tx_data, 32'd0);
        chk("reset_last", 32'(tx_last), 32'd0);
        rst_n = 1'b1;
        rx.delete();

        // Single sample at cycle 5
        start = 1'b1; pc = 32'h10; tx_ready = 1'b1;
        tick(5); sample = 1'b1; tick(1); sample = 1'b0;
        tick(12);
        chk("t1_nwords", 32'(rx.size()), 32'(NW));
        chk("t1_w0", rx[0][31:0], 32'hA5000000);
        chk("t1_w1", rx[1][31:0], 32'd5);
        chk("t1_w2", rx[2][31:0], 32'h10);
        chk("t1_w3", rx[3][31:0], 32'd0);
        chk("t1_w2_notlast", 32'(rx[2][32]), 32'd0);
        chk("t1_last", 32'(rx[NW-1][32]), 32'd1);

        // Counters in frame
        do_reset();
        start = 1'b1;
        tick(1); stall = 1'b1;
        tick(1); flush = 1'b1;
        tick(1); flush = 1'b0;
        tick(1); stall = 1'b0;
        tick(2); sample = 1'b1;
        tick(1); sample = 1'b0;
        tick(12);
        chk("t2_w0", rx[0][31:0], 32'hA5000000);
        chk("t2_w1", rx[1][31:0], 32'd6);
        chk("t2_w3", rx[3][31:0], 32'h00030001);

        // Overflow with sink stalled
        do_reset();
        start = 1'b1; tx_ready = 1'b0; pc = 32'h20;
        tick(1); sample = 1'b1;
        tick(4); sample = 1'b0; tx_ready = 1'b1;
        tick(3 * NW);
        sample = 1'b1; tick(1); sample = 1'b0;
        tick(NW + 6);
        chk("t3_nwords", 32'(rx.size()), 32'(3 * NW));
        chk("t3_f0_w0", rx[0][31:0], 32'hA5000000);
        chk("t3_f0_w1", rx[1][31:0], 32'd1);
        chk("t3_f1_w0", rx[NW][31:0], 32'hA5000001);
        chk("t3_f1_w1", rx[NW+1][31:0], 32'd2);
        chk("t3_f2_w0", rx[2*NW][31:0], 32'hA5020002);

        // Backpressure, two queued frames
        do_reset();
        start = 1'b1; tx_ready = 1'b1;
        tick(1); sample = 1'b1; pc = 32'h200;
        tick(1); pc = 32'h204;
        tick(1); sample = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tx_ready = (i % 2 == 0);
            tick(1);
        end
        tx_ready = 1'b1;
        tick(10);
        chk("t4_nwords", 32'(rx.size()), 32'(2 * NW));
        chk("t4_f0_w0", rx[0][31:0], 32'hA5000000);
        chk("t4_f0_w2", rx[2][31:0], 32'h200);
        chk("t4_f1_w0", rx[NW][31:0], 32'hA5000001);
        chk("t4_f1_w2", rx[NW+2][31:0], 32'h204);

        // Sustained throughput across frame boundaries
        do_reset();
        start = 1'b1; tx_ready = 1'b1; pc = 32'h300;
        first_v = -1; last_v = -1;
        tick(1); sample = 1'b1; tick(1); sample = 1'b0;
        tick(NW);
        repeat (3) begin
            sample = 1'b1; tick(1); sample = 1'b0;
            tick(NW - 1);
        end
        tick(NW + 4);
        chk("t4b_nwords", 32'(rx.size()), 32'(4 * NW));
        chk("t4b_span", 32'(last_v - first_v + 1), 32'(4 * NW));
        chk("t4b_f1_w0", rx[NW][31:0], 32'hA5000001);
        chk("t4b_f1_w1", rx[NW+1][31:0], 32'(2 + NW));
        chk("t4b_f3_w0", rx[3*NW][31:0], 32'hA5000003);

        // Mid-frame asynchronous reset
        do_reset();
        start = 1'b1; tx_ready = 1'b1; pc = 32'h400;
        tick(1); sample = 1'b1; tick(1); sample = 1'b0;
        tick(3);
        chk("t5_w2_shown", tx_data, 32'h400);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 32'(tx_valid), 32'd0);
        chk("t5_async_data", tx_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rx.delete();
        tick(3); sample = 1'b1; tick(1); sample = 1'b0;
        tick(NW + 6);
        chk("t5_w0", rx[0][31:0], 32'hA5000000);
        chk("t5_w1", rx[1][31:0], 32'd3);

`ifdef CPU_TRACE_TX_REGS_EN
        // Register words
        do_reset();
        start = 1'b1; tx_ready = 1'b1; pc = 32'h500;
        tick(1); sample = 1'b1; tick(1); sample = 1'b0;
        tick(5);
        chk("t6_w4_data", tx_data, 32'd0);
        chk("t6_w4_reg_addr", 32'(reg_addr), 32'd1);
        tick(1);
        chk("t6_w5_data", tx_data, 32'h7);
        chk("t6_w5_last", 32'(tx_last), 32'd1);
        tick(5);
        chk("t6_rx_w4", rx[4][31:0], 32'd0);
        chk("t6_rx_w5", rx[5][31:0], 32'h7);
        chk("t6_rx_last", 32'(rx[5][32]), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_trace_tx.md
# cpu_trace_tx

Per-cycle execution trace transmitter for the pipelined CPU.
- Counts cycles, stalls and flushes.
- Captures PC snapshots on a sample strobe into a small snapshot FIFO.
- Serialises each snapshot as a fixed-length word frame over a valid/ready stream, for an off-chip logger or bench-side decoder.
- Sits beside `CPU`, taking PC, hazard-unit stall/flush and, optionally, a spare register-file read port.

## Interface
- `SNAP_DEPTH`, 2: snapshot FIFO entries; power of 2, ≥2.
- `NREG`, 8: register words per frame when `TRACE_REGS_EN` is defined; 1..32.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `start_i` in 1: CPU running; gates all counting and sampling.
- `pc_i` in 32: current PC (`PC.pc_o`).
- `stall_i` in 1: pipeline stall this cycle.
- `flush_i` in 1: IF/ID flush this cycle.
- `sample_i` in 1: capture snapshot this cycle.
- `reg_addr_o` out 5: register-file read address (only with `TRACE_REGS_EN`, else absent).
- `reg_data_i` in 32: register-file read data, combinational from `reg_addr_o` (only with `TRACE_REGS_EN`).
- `tx_data_o` out 32: frame word, registered.
- `tx_valid_o` out 1: word valid.
- `tx_ready_i` in 1: sink accepts word.
- `tx_last_o` out 1: final word of frame.

## Operation
- Counters, all cleared by reset and counting only at edges where `start_i`=1:
  - `cycle_cnt`: 32-bit, wraps.
  - `stall_cnt`: 16-bit, +1 on `stall_i`, saturates at 16'hFFFF.
  - `flush_cnt`: 16-bit, +1 on `flush_i`, saturates at 16'hFFFF.
  - `seq`: 16-bit, +1 per accepted push, wraps.
  - `drop_cnt`: 8-bit, +1 per dropped sample, saturates at 8'hFF.
- Snapshot fields: {`seq`, `drop_cnt`, `cycle_cnt`, `pc_i`, `stall_cnt`, `flush_cnt`}.
  - Counter fields hold pre-increment values at the sampling edge.
  - `stall_i`/`flush_i` of the sampled cycle are not included.
- Push occurs when `sample_i`&`start_i`.
  - Accepted when FIFO not full, or when a pop occurs at the same edge.
  - Accepted push clears `drop_cnt` and increments `seq`.
  - Otherwise the sample is dropped, `drop_cnt`+1.
- Frame words, in order:
  - W0 = {8'hA5, `drop_cnt`, `seq`}.
  - W1 = `cycle_cnt`.
  - W2 = `pc_i`.
  - W3 = {`stall_cnt`, `flush_cnt`}.
  - W4..W(3+NREG): registers 0..NREG-1, only with `TRACE_REGS_EN`.
- FSM:
  - IDLE → SEND when FIFO non-empty; W0 is loaded at that edge.
  - SEND: on each accepted word (`tx_valid_o`&`tx_ready_i`), load the next word.
  - On the accepted last word, pop the FIFO. If the FIFO is still non-empty, load the next frame's W0 at the same edge (no bubble); else go to IDLE.
- Handshake:
  - `tx_data_o`/`tx_last_o` stable while `tx_valid_o`=1 and `tx_ready_i`=0.
  - `tx_valid_o` never drops mid-frame.
- Register words:
  - `reg_addr_o` = index of the next register word to be loaded. `reg_data_i` is captured into `tx_data_o` at the load edge.
  - The value reflects the register file at transmit time, not sample time.
  - `reg_addr_o` = 0 when no register word is pending.
- `start_i` falling mid-frame: the frame and any queued snapshots still drain; counters hold.

## Timing
- Reset (async assert): `tx_valid_o`=0, `tx_last_o`=0, `tx_data_o`=0, `reg_addr_o`=0, FIFO empty, all counters 0, FSM IDLE. Assertion mid-frame aborts immediately.
- Latency: `sample_i` at edge E0 with FIFO empty and FSM IDLE → `tx_valid_o`=1 with W0 after edge E1.
- Frame length with `tx_ready_i` held high: 4 cycles, or 4+NREG cycles with register words.
- Sustained throughput: one word per cycle, including across frame boundaries.

## Configuration
- `CPU_TRACE_TX_REGS_EN`:
  - Defined: `reg_addr_o`/`reg_data_i` ports exist; frames are 4+NREG words; `tx_last_o` on W(3+NREG).
  - Undefined: ports removed; frames are 4 words; `tx_last_o` on W3.

## Test plan
- Single sample, no backpressure:
  - Stimulus: reset, `start_i`=1, `pc_i`=32'h10, `sample_i` pulse at cycle 5, `tx_ready_i`=1.
  - Response: W0=32'hA5000000, W1=5, W2=32'h10, W3=0, `tx_last_o` on W3.
- Counters in frame:
  - Stimulus: `stall_i`=1 cycles 1-3, `flush_i`=1 cycle 2, sample at cycle 6.
  - Response: W3=32'h00030001, W1=6.
- Overflow (SNAP_DEPTH=2):
  - Stimulus: `tx_ready_i`=0, samples at cycles 1-4, then `tx_ready_i`=1.
  - Response: two frames with `seq` 0,1 and `drop_cnt` 0. The next sample pushed carries `drop_cnt`=2, `seq`=2.
- Backpressure:
  - Stimulus: `tx_ready_i` toggled 1/0 each cycle.
  - Response: data and valid held on every stalled cycle; all 4 words delivered in order; no bubbles between back-to-back frames when ready.
- Mid-frame reset:
  - Stimulus: assert `rst_i`=0 during W2.
  - Response: `tx_valid_o`=0 without waiting for a clock edge; after release, the next sample reports `seq`=0, `cycle_cnt` restarting from 0.
- `CPU_TRACE_TX_REGS_EN`, NREG=2:
  - Stimulus: register model with R0=0, R1=32'h7.
  - Response: W4=0, W5=7, `tx_last_o` on W5, `reg_addr_o`=1 in the cycle W4 is presented.
